// File: rtl/pc_stack_unit.sv
// Program counter with hardware call/interrupt return stack.
// Optional macro PC_STACK_FLAGS_EN saves {zero, carry} on interrupt entry and restores them on reti.
module pc_stack_unit #(
    parameter int              PC_W      = 12,
    parameter int              OFF_W     = 8,
    parameter int              DEPTH     = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] ISR_VEC   = 12'h010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en_i,
    input  logic [3:0]       pc_oper_i,
    input  logic             jbs_i,
    input  logic             ret_i,
    input  logic             int_i,
    input  logic             reti_i,
    input  logic [PC_W-1:0]  target_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic             zero_i,
    input  logic             carry_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             stack_full_o,
    output logic             stack_empty_o,
    output logic             stack_err_o,
    output logic             in_isr_o,
    output logic [1:0]       flags_o,
    output logic             flags_ld_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;
`ifdef PC_STACK_FLAGS_EN
    localparam int ENTRY_W = PC_W + 2;
`else
    localparam int ENTRY_W = PC_W;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               err_q, err_d;
    logic               in_isr_q, in_isr_d;
    logic [1:0]         flags_q, flags_d;
    logic               flags_ld_q, flags_ld_d;

    logic               mem_we;
    logic [ENTRY_W-1:0] mem_wdata;
    logic [AW-1:0]      wr_addr, rd_addr;
    logic [ENTRY_W-1:0] rd_entry;
    logic [PC_W-1:0]    pc_plus1, pc_branch;
    logic               full, empty, int_acc, taken;

    assign full      = (sp_q == SP_W'(DEPTH));
    assign empty     = (sp_q == '0);
    assign wr_addr   = sp_q[AW-1:0];
    assign rd_addr   = AW'(sp_q - SP_W'(1));
    assign rd_entry  = mem_q[rd_addr];
    assign pc_plus1  = pc_q + PC_W'(1);
    assign pc_branch = pc_q + PC_W'(signed'(off_i));
    assign int_acc   = int_i && !in_isr_q;

    always_comb begin
        unique case (pc_oper_i)
            4'b0010: taken = zero_i;
            4'b0011: taken = !zero_i;
            4'b0100: taken = carry_i;
            4'b0101: taken = !carry_i;
            4'b0110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // One action per enabled cycle; a full push or empty pop sets the sticky error but the PC still moves.
    always_comb begin
        pc_d       = pc_q;
        sp_d       = sp_q;
        err_d      = err_q;
        in_isr_d   = in_isr_q;
        flags_d    = flags_q;
        flags_ld_d = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (pc_en_i) begin
            if (int_acc || (!reti_i && !ret_i && jbs_i)) begin
`ifdef PC_STACK_FLAGS_EN
                mem_wdata = int_acc ? {pc_q, zero_i, carry_i} : {pc_plus1, 2'b00};
`else
                mem_wdata = int_acc ? pc_q : pc_plus1;
`endif
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SP_W'(1);
                end
                pc_d     = int_acc ? ISR_VEC : target_i;
                in_isr_d = int_acc ? 1'b1 : in_isr_q;
            end else if (reti_i || ret_i) begin
                if (empty) begin
                    err_d = 1'b1;
                    pc_d  = RESET_VEC;
                end else begin
                    sp_d = sp_q - SP_W'(1);
                    pc_d = rd_entry[ENTRY_W-1 -: PC_W];
                end
                if (reti_i) begin
                    in_isr_d = 1'b0;
`ifdef PC_STACK_FLAGS_EN
                    flags_d    = empty ? 2'b00 : rd_entry[1:0];
                    flags_ld_d = 1'b1;
`endif
                end
            end else begin
                if (pc_oper_i == 4'b0001) begin
                    pc_d = target_i;
                end else if (taken) begin
                    pc_d = pc_branch;
                end else begin
                    pc_d = pc_plus1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            sp_q       <= '0;
            err_q      <= 1'b0;
            in_isr_q   <= 1'b0;
            flags_q    <= 2'b00;
            flags_ld_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            in_isr_q   <= in_isr_d;
            flags_q    <= flags_d;
            flags_ld_q <= flags_ld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= mem_wdata;
        end
    end

    assign pc_o          = pc_q;
    assign stack_full_o  = full;
    assign stack_empty_o = empty;
    assign stack_err_o   = err_q;
    assign in_isr_o      = in_isr_q;
    assign flags_o       = flags_q;
    assign flags_ld_o    = flags_ld_q;

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter and hardware return-stack stage directly downstream of the control unit.
- Consumes the control unit's PC-control strobes (PCEN, PCoper, ret, jbs, reti, int) plus a target/offset from the datapath and ALU flags.
- Produces the registered fetch address for the instruction bus.
- Owns the call/interrupt return stack, including overflow/underflow detection.

Parameters:
- PC_W, 12, program-counter / instruction-address width in bits.
- OFF_W, 8, signed relative-branch offset width.
- DEPTH, 8, return-stack entries; power of 2, at least 2.
- RESET_VEC, 0, PC value after reset and after an underflow pop.
- ISR_VEC, 12'h010, PC loaded on interrupt entry.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- pc_en_i, in, 1, PC update enable; nothing changes when 0.
- pc_oper_i, in, 4, PC operation code; see Behaviour.
- jbs_i, in, 1, jump to subroutine.
- ret_i, in, 1, return from subroutine.
- int_i, in, 1, interrupt entry.
- reti_i, in, 1, return from interrupt.
- target_i, in, PC_W, absolute jump/call target.
- off_i, in, OFF_W, signed relative branch offset.
- zero_i, in, 1, ALU zero flag.
- carry_i, in, 1, ALU carry flag.
- pc_o, out, PC_W, registered fetch address.
- stack_full_o, out, 1, stack pointer equals DEPTH.
- stack_empty_o, out, 1, stack pointer equals 0.
- stack_err_o, out, 1, sticky overflow/underflow flag.
- in_isr_o, out, 1, interrupt service in progress.
- flags_o, out, 2, restored {zero, carry}; feature dependent.
- flags_ld_o, out, 1, one-cycle pulse when flags_o is valid.

Behaviour:
- Reset: rst=1 at a clock edge sets pc_o=RESET_VEC, sp=0, stack_err_o=0, in_isr_o=0, flags_o=0, flags_ld_o=0.
  - Stack RAM contents are don't-care.
  - Reset wins over every other input, including mid-operation.
- pc_en_i=0: all state holds. flags_ld_o=0.
- pc_en_i=1: exactly one action, chosen by this priority: int_i > reti_i > ret_i > jbs_i > pc_oper_i.
  - int_i while in_isr_o=1 is ignored and falls through to the next priority.
- int_i (accepted):
  - push pc_o (the resume address).
  - pc_o <= ISR_VEC.
  - in_isr_o <= 1.
- reti_i:
  - pop into pc_o.
  - in_isr_o <= 0.
- ret_i: pop into pc_o.
- jbs_i:
  - push pc_o+1 (modulo 2^PC_W).
  - pc_o <= target_i.
- pc_oper_i (applies when no strobe is active):
  - 0000: pc_o+1.
  - 0001: target_i.
  - 0010: BZ, taken if zero_i.
  - 0011: BNZ, taken if !zero_i.
  - 0100: BC, taken if carry_i.
  - 0101: BNC, taken if !carry_i.
  - 0110: BRA, always taken.
  - All other codes: pc_o+1.
  - Taken branch: pc_o + sign_extend(off_i), truncated to PC_W (wraps).
  - Not taken: pc_o+1.
- Latency: the new pc_o is visible in the cycle after the enabling edge, with no combinational path from inputs to pc_o.
- Push:
  - mem[sp] <= value; sp <= sp+1.
  - If full: the push is discarded, sp holds, stack_err_o <= 1, and the jump still happens.
- Pop:
  - sp <= sp-1; pc_o <= mem[sp-1].
  - If empty: sp holds, stack_err_o <= 1, pc_o <= RESET_VEC.
- stack_err_o clears only on rst.
- stack_full_o and stack_empty_o are combinational from sp.
- sp width is clog2(DEPTH)+1.
- PC increments and branch targets wrap at 2^PC_W with no error.

Optional Feature:
- Macro: PC_STACK_FLAGS_EN.
- When defined:
  - Stack entries are PC_W+2 wide.
  - Interrupt entry pushes {pc_o, zero_i, carry_i}.
  - reti_i restores the PC, drives flags_o with the saved flags, and pulses flags_ld_o for one cycle.
  - An underflowing reti_i gives flags_o=00 with flags_ld_o=1.
  - Call pushes store flags as 00 and never assert flags_ld_o.
- When undefined:
  - Entries are PC_W wide.
  - flags_o=00 and flags_ld_o=0 always.

Test Plan:
- Reset and sequential fetch: rst for 2 cycles, then pc_en_i=1, pc_oper_i=0000 for 3 cycles -> pc_o reads 0, 1, 2, 3. With pc_en_i=0 pc_o holds at 3.
- Branches:
  - pc_o=0x020, BZ with zero_i=1 and off_i=8'hFC -> pc_o=0x01C.
  - BNZ with zero_i=1 -> pc_o=0x01D.
  - BRA with off_i=8'h05 at pc_o=0xFFE -> pc_o=0x003 (wrap).
- Call/return nesting: jbs_i at pc 0x005 to 0x100, then jbs_i at 0x100 to 0x200, then ret_i twice -> pc_o=0x101, then 0x006. stack_empty_o=1 at the end; stack_err_o=0.
- Overflow/underflow:
  - DEPTH+1 consecutive jbs_i -> stack_full_o=1 after DEPTH calls and stack_err_o=1 after the extra call; pc_o still equals target_i.
  - After reset, ret_i on the empty stack -> pc_o=RESET_VEC and stack_err_o=1.
- Interrupt: pc_o=0x040, int_i with zero_i=1 and carry_i=0 -> pc_o=0x010 and in_isr_o=1. A second int_i is ignored (pc_oper 0000 applies, giving 0x011). reti_i -> pc_o=0x040 and in_isr_o=0. With PC_STACK_FLAGS_EN, flags_o=10 and flags_ld_o pulses once.
- Priority/reset: int_i, ret_i and jbs_i asserted together -> interrupt entry only, sp+1. rst asserted in the same cycle as jbs_i -> pc_o=RESET_VEC and sp=0.
